// File: rtl/multicycle_core_p_if.sv
// Request/acknowledge port between the core and its unified
// instruction/data memory.
interface multicycle_core_p_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/multicycle_core_p.sv
// Multicycle 4-register load/store core with flags, relative branches,
// wait-state memory port, run/step modes, HALT and retire counter.
module multicycle_core_p #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                run_mode,
    input  logic                step,
    multicycle_core_p_if.master mem,
    output logic                halted,
    output logic                busy,
    output logic                flag_n,
    output logic                flag_z,
    output logic [ADDR_W-1:0]   pc,
    output logic [CNT_W-1:0]    retired,
    input  logic [1:0]          dbg_sel,
    output logic [DATA_W-1:0]   dbg_data,
    output logic [2:0]          state_o
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALTED = 3'd6
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] regs_q [4];
    logic [DATA_W-1:0] a_q, b_q, alu_q;
    logic [7:0]        ir_q;
    logic [ADDR_W-1:0] pc_q;
    logic              n_q, z_q;
    logic [CNT_W-1:0]  ret_q;
    logic              req_q, we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic [1:0]        ra, rb, dst;
    logic [3:0]        op;
    logic              op_ori, op_shf, op_ld, op_st;
    logic              op_add, op_sub, op_nand, op_halt;
    logic              is_alu, taken, retire;
    logic [DATA_W-1:0] alu_d;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        ra      = ir_q[7:6];
        rb      = ir_q[5:4];
        op      = ir_q[3:0];
        op_ori  = ir_q[2:0] == 3'b111;
        op_shf  = ir_q[2:0] == 3'b011;
        op_ld   = op == 4'b0000;
        op_st   = op == 4'b0010;
        op_add  = op == 4'b0100;
        op_sub  = op == 4'b0110;
        op_nand = op == 4'b1000;
        op_halt = op == 4'b0001;
        is_alu  = op_ori | op_shf | op_add | op_sub | op_nand;
        dst     = op_ori ? 2'd1 : ra;
        taken   = (op == 4'b0101 &&  z_q) ||
                  (op == 4'b1001 && !z_q) ||
                  (op == 4'b1101 && !n_q);
        pc_d = pc_q;
        if (state_q == S_EXEC && taken)
            pc_d = pc_q + ADDR_W'(signed'(ir_q[7:4]));
        alu_d = '0;
        unique case (1'b1)
            op_add:  alu_d = a_q + b_q;
            op_sub:  alu_d = a_q - b_q;
            op_nand: alu_d = ~(a_q & b_q);
            op_ori:  alu_d = a_q | DATA_W'(ir_q[7:3]);
            op_shf:  alu_d = ir_q[3] ? a_q >> rb : a_q << rb;
            default: alu_d = '0;
        endcase
        // NOPs and branches retire from EXEC, one cycle after DECODE
        retire = (state_q == S_EXEC && !is_alu) ||
                 (state_q == S_MEM && mem.mem_ack && we_q) ||
                 (state_q == S_WB);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            ir_q    <= '0;
            pc_q    <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            ret_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (run_mode || step) begin
                        state_q <= S_FETCH;
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        addr_q  <= pc_q;
                    end
                end
                S_FETCH: begin
                    if (mem.mem_ack) begin
                        ir_q    <= mem.mem_rdata[7:0];
                        pc_q    <= pc_q + 1'b1;
                        req_q   <= 1'b0;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q <= regs_q[dst];
                    b_q <= regs_q[rb];
                    if (op_ld || op_st) begin
                        state_q <= S_MEM;
                        req_q   <= 1'b1;
                        we_q    <= op_st;
                        addr_q  <= regs_q[rb][ADDR_W-1:0];
                        if (op_st) wdata_q <= regs_q[ra];
                    end else if (op_halt) begin
                        state_q <= S_HALTED;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    pc_q <= pc_d;
                    if (is_alu) begin
                        alu_q   <= alu_d;
                        n_q     <= alu_d[DATA_W-1];
                        z_q     <= alu_d == '0;
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem.mem_ack) begin
                        req_q <= 1'b0;
                        we_q  <= 1'b0;
                        if (!we_q) begin
                            alu_q   <= mem.mem_rdata;
                            state_q <= S_WB;
                        end
                    end
                end
                S_WB:     regs_q[dst] <= alu_q;
                S_HALTED: state_q <= S_HALTED;
                default:  state_q <= S_IDLE;
            endcase
            if (retire) begin
                ret_q   <= ret_q + 1'b1;
                state_q <= run_mode ? S_FETCH : S_IDLE;
                req_q   <= run_mode;
                we_q    <= 1'b0;
                if (run_mode) addr_q <= pc_d;
            end
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign halted        = state_q == S_HALTED;
    assign busy          = !(state_q == S_IDLE || state_q == S_HALTED);
    assign flag_n        = n_q;
    assign flag_z        = z_q;
    assign pc            = pc_q;
    assign retired       = ret_q;
    assign dbg_data      = regs_q[dbg_sel];
    assign state_o       = state_q;
endmodule
